// File: rtl/wave_player.sv
// Wave-table sink: captures the initializer's sample stream into a RAM, then
// plays it back to the DAC path under a DDS phase accumulator.
module wave_player #(
    parameter int DATA_W  = 9,
    parameter int ADDR_W  = 8,
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  data,
    input  logic               data_v,
    input  logic               initialized,
    input  logic               run,
    input  logic [PHASE_W-1:0] freq_word,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_v,
    output logic               loaded,
    output logic               error
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]         state;
    logic [ADDR_W:0]    wr_cnt;
    logic [PHASE_W-1:0] phase;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               wr_en_p0;
    logic               full_p0;
    logic [ADDR_W:0]    wr_cnt_nxt_p0;
    logic               rd_en_p0;
    logic [ADDR_W-1:0]  rd_addr_p0;

    // wr_cnt never exceeds DEPTH, so its top bit alone flags a full table
    assign full_p0       = wr_cnt[ADDR_W];
    assign wr_en_p0      = (state == S_LOAD) && data_v && !full_p0;
    assign wr_cnt_nxt_p0 = wr_cnt + {{ADDR_W{1'b0}}, wr_en_p0};
    assign rd_en_p0      = (state == S_PLAY) && run;
    assign rd_addr_p0    = phase[PHASE_W-1 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en_p0)
            mem[wr_cnt[ADDR_W-1:0]] <= data;
    end

    // ---- stage p0 -> p1: RAM read register doubles as the output sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= '0;
        end else if (rd_en_p0) begin
            sample <= mem[rd_addr_p0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOAD;
            wr_cnt   <= '0;
            phase    <= '0;
            sample_v <= 1'b0;
            loaded   <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    wr_cnt   <= wr_cnt_nxt_p0;
                    sample_v <= 1'b0;
                    // initialized is judged against the count including this cycle's write
                    if (data_v && full_p0) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else if (initialized) begin
                        if (wr_cnt_nxt_p0[ADDR_W]) begin
                            state  <= S_PLAY;
                            loaded <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    sample_v <= run;
                    if (run)
                        phase <= phase + freq_word;
                end
                S_ERR: begin
                    sample_v <= 1'b0;
                    loaded   <= 1'b0;
                    error    <= 1'b1;
                end
                default: begin
                    state    <= S_ERR;
                    sample_v <= 1'b0;
                    loaded   <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/wave_player.md
Name: wave_player

Overview:
- Sink end of the wave-table initialization stream.
- Captures the 9-bit sample stream (data/data_v, terminated by initialized) into an internal wave RAM.
- Then plays the table back to the DAC path under a DDS phase accumulator.
- Sits between the table initializer and the DAC output register in the arbitrary wave generator.

Parameters:
DATA_W, 9, sample width; must equal the initializer's data width
ADDR_W, 8, log2 of table depth; DEPTH = 2**ADDR_W entries
PHASE_W, 24, phase accumulator width; must be at least ADDR_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
data  input  DATA_W  sample from the initializer
data_v  input  1  data valid; one sample per cycle when high
initialized  input  1  initializer done; level, stays high once set
run  input  1  playback enable
freq_word  input  PHASE_W  phase increment per clk during playback
sample  output  DATA_W  registered playback sample
sample_v  output  1  sample is a valid playback value this cycle
loaded  output  1  table fully captured and accepted
error  output  1  load protocol violation; sticky until rst

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: sample=0, sample_v=0, loaded=0, error=0, wr_cnt=0, phase=0, state=LOAD.
- wr_cnt is ADDR_W+1 bits wide.
- RAM: DEPTH x DATA_W, synchronous write, synchronous read (1-cycle), inferable as block RAM. RAM contents are not reset.
- States: LOAD, PLAY, ERR.
- LOAD:
  - data_v=1 and wr_cnt<DEPTH: mem[wr_cnt[ADDR_W-1:0]] <= data; wr_cnt++.
  - data_v=1 and wr_cnt==DEPTH: overflow. Go to ERR; the write is discarded.
  - initialized=1 with wr_cnt==DEPTH, evaluated after this cycle's write: go to PLAY; loaded=1 from the next cycle.
  - initialized=1 with wr_cnt<DEPTH after this cycle's write: underflow. Go to ERR.
  - data_v and initialized high in the same cycle: the write counts first, then initialized is evaluated. Example: the 256th write plus initialized in the same cycle is legal.
- PLAY:
  - loaded stays 1. data_v is ignored; no writes; error does not change.
  - run=1: phase <= phase + freq_word, wrapping mod 2**PHASE_W. RAM read address = phase[PHASE_W-1 -: ADDR_W], taken from the current (pre-update) phase.
  - Latency: the address is presented at cycle N. sample holds mem[addr] and sample_v=1 at cycle N+1, registered from the RAM output.
  - run=0: phase holds, sample holds its last value, sample_v=0 on the cycle after run falls.
  - run falling then rising resumes from the held phase; there is no phase reset.
  - freq_word=0 with run=1: the same sample repeats and sample_v stays 1.
  - freq_word changes take effect on the next accumulate; there is no glitch filtering.
- ERR: error=1, loaded=0, sample_v=0, sample frozen. Only rst leaves ERR.
- Reset mid-load or mid-play: all registers return to reset values immediately. The next load restarts at address 0.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Normal load, ADDR_W=4 (DEPTH=16): write data=0x000..0x00F on 16 consecutive data_v cycles, then initialized=1 -> loaded=1 on the following cycle, error=0.
- Playback step, same table, PHASE_W=8, freq_word=0x10, run=1 -> sample_v rises 1 cycle after run; sample sequence 0x000,0x001,...,0x00F,0x000 (wraps), one new value per clk.
- Half-rate and hold: freq_word=0x08 -> each sample repeated 2 cycles. Drop run for 3 cycles -> sample_v=0, sample unchanged. Re-raise run -> sequence continues from the next address, not from 0.
- Underflow: 10 writes, then initialized=1 -> error=1 next cycle, loaded=0. Further data_v and run have no effect until rst.
- Overflow and boundary: 17th data_v before initialized -> error=1. Separately, 16th write and initialized in the same cycle -> loaded=1, error=0.
- Async reset mid-playback: assert rst between clock edges during PLAY -> sample=0, sample_v=0, loaded=0 immediately, with no clock edge. After release, a fresh 16-sample load of 0x1FF..0x1F0 then plays 0x1FF first.
